// File: rtl/microcode_seq_if.sv
// Signal bundle between the instruction sequencer, the memory interface and the microcode ROM.
// The sequencer connects through the master modport; the memory/ROM/interrupt side uses slave.
interface microcode_seq_if;
    logic [7:0] mem_data;
    logic       mem_ready;
    logic       ctrl_done;
    logic       ctrl_mem;
    logic       irq_pending;
    logic       ime;
    logic [8:0] ucode_addr;
    logic [2:0] step;
    logic       exec_valid;
    logic       fetch_req;
    logic       irq_ack;
    logic       halted;
    logic       seq_err;

    modport master (
        input  mem_data, mem_ready, ctrl_done, ctrl_mem, irq_pending, ime,
        output ucode_addr, step, exec_valid, fetch_req, irq_ack, halted, seq_err
    );

    modport slave (
        output mem_data, mem_ready, ctrl_done, ctrl_mem, irq_pending, ime,
        input  ucode_addr, step, exec_valid, fetch_req, irq_ack, halted, seq_err
    );
endinterface

// File: rtl/microcode_seq.sv
// Microcode instruction sequencer: opcode fetch, 0xCB prefix folding, step counting, interrupt dispatch.
// Define MICROSEQ_HALT_EN to build the HALT state; otherwise 0x76 runs as an ordinary instruction.
module microcode_seq (
    input  logic            clk,
    input  logic            rst,
    microcode_seq_if.master bus
);
    localparam logic [8:0] INT_OPCODE    = 9'h12A;
    localparam logic [7:0] PREFIX_OPCODE = 8'hCB;
    localparam logic [2:0] MAX_STEP      = 3'd7;

`ifdef MICROSEQ_HALT_EN
    localparam logic [7:0] HALT_OPCODE   = 8'h76;
    typedef enum logic [2:0] {IDLE, FETCH, FETCH_CB, EXEC, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, FETCH_CB, EXEC} state_t;
`endif

    state_t     state_reg;
    logic [8:0] addr_reg;
    logic [2:0] step_reg;
    logic       exec_valid_reg;
    logic       fetch_req_reg;
    logic       irq_ack_reg;
    logic       seq_err_reg;
    // Tracks the dispatch pseudo-instruction explicitly: 9'h12A is also a legal CB-page index.
    logic       dispatch_reg;

    logic mem_stall;
    logic step_last;
    logic take_irq;

    assign mem_stall = bus.ctrl_mem && !bus.mem_ready;
    assign step_last = (step_reg == MAX_STEP);
    assign take_irq  = bus.irq_pending && bus.ime && !dispatch_reg;

`ifdef MICROSEQ_HALT_EN
    logic halted_reg;
    assign bus.halted = halted_reg;
`else
    assign bus.halted = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            step_reg       <= '0;
            exec_valid_reg <= 1'b0;
            fetch_req_reg  <= 1'b0;
            irq_ack_reg    <= 1'b0;
            seq_err_reg    <= 1'b0;
            dispatch_reg   <= 1'b0;
`ifdef MICROSEQ_HALT_EN
            halted_reg     <= 1'b0;
`endif
        end else begin
            irq_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    state_reg     <= FETCH;
                    fetch_req_reg <= 1'b1;
                end
                FETCH, FETCH_CB: begin
                    if (bus.mem_ready) begin
                        if (state_reg == FETCH && bus.mem_data == PREFIX_OPCODE) begin
                            state_reg <= FETCH_CB;
                        end else begin
                            state_reg      <= EXEC;
                            addr_reg       <= {(state_reg == FETCH_CB), bus.mem_data};
                            step_reg       <= '0;
                            fetch_req_reg  <= 1'b0;
                            exec_valid_reg <= 1'b1;
                            dispatch_reg   <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    if (!mem_stall) begin
                        // Running off the last step is reported, then handled like a normal end.
                        if (bus.ctrl_done || step_last) begin
                            if (!bus.ctrl_done) begin
                                seq_err_reg <= 1'b1;
                            end
                            if (take_irq) begin
                                addr_reg     <= INT_OPCODE;
                                step_reg     <= '0;
                                irq_ack_reg  <= 1'b1;
                                dispatch_reg <= 1'b1;
`ifdef MICROSEQ_HALT_EN
                            end else if (addr_reg == {1'b0, HALT_OPCODE}) begin
                                state_reg      <= HALT;
                                exec_valid_reg <= 1'b0;
                                halted_reg     <= 1'b1;
`endif
                            end else begin
                                state_reg      <= FETCH;
                                exec_valid_reg <= 1'b0;
                                fetch_req_reg  <= 1'b1;
                            end
                        end else begin
                            step_reg <= step_reg + 3'd1;
                        end
                    end
                end
`ifdef MICROSEQ_HALT_EN
                HALT: begin
                    if (bus.irq_pending) begin
                        halted_reg <= 1'b0;
                        if (bus.ime) begin
                            state_reg      <= EXEC;
                            exec_valid_reg <= 1'b1;
                            addr_reg       <= INT_OPCODE;
                            step_reg       <= '0;
                            irq_ack_reg    <= 1'b1;
                            dispatch_reg   <= 1'b1;
                        end else begin
                            state_reg     <= FETCH;
                            fetch_req_reg <= 1'b1;
                        end
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ucode_addr = addr_reg;
    assign bus.step       = step_reg;
    assign bus.exec_valid = exec_valid_reg;
    assign bus.fetch_req  = fetch_req_reg;
    assign bus.irq_ack    = irq_ack_reg;
    assign bus.seq_err    = seq_err_reg;
endmodule

// File: tb/tb_microcode_seq.sv
// Self-checking bench for microcode_seq: directed vector table, async-reset sequence,
// then randomized stimulus against an instruction-level reference model.
module tb_microcode_seq;
    logic clk = 1'b0;
    logic rst;

    microcode_seq_if bus ();

    microcode_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef MICROSEQ_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       rdy, done, mem, irq, ie;
        logic [8:0] addr;
        logic [2:0] stp;
        logic       ev, fr, ack, hlt, err;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(logic [7:0] data, logic rdy, logic done, logic mem, logic irq, logic ie,
                                logic [8:0] addr, logic [2:0] stp,
                                logic ev, logic fr, logic ack, logic hlt, logic err);
        vec_t v;
        v.data = data; v.rdy = rdy; v.done = done; v.mem = mem; v.irq = irq; v.ie = ie;
        v.addr = addr; v.stp = stp; v.ev = ev; v.fr = fr; v.ack = ack; v.hlt = hlt; v.err = err;
        return v;
    endfunction

    function automatic logic [16:0] dut_out();
        return {bus.ucode_addr, bus.step, bus.exec_valid, bus.fetch_req, bus.irq_ack, bus.halted, bus.seq_err};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got addr=%h step=%0d ev/fr/ack/hlt/err=%b required addr=%h step=%0d ev/fr/ack/hlt/err=%b",
                     name, got[16:8], got[7:5], got[4:0], exp[16:8], exp[7:5], exp[4:0]);
        end
    endtask

    task automatic drive(input logic [7:0] data, input logic rdy, input logic done,
                         input logic mem, input logic irq, input logic ie);
        bus.mem_data    = data;
        bus.mem_ready   = rdy;
        bus.ctrl_done   = done;
        bus.ctrl_mem    = mem;
        bus.irq_pending = irq;
        bus.ime         = ie;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks what the core is doing at instruction level.
    bit       m_idle, m_fetching, m_prefixed, m_executing, m_sleeping, m_in_irq;
    bit [8:0] m_index;
    int       m_step;
    bit       m_ack, m_err;

    task automatic model_reset();
        m_idle = 1; m_fetching = 0; m_prefixed = 0; m_executing = 0; m_sleeping = 0; m_in_irq = 0;
        m_index = '0; m_step = 0; m_ack = 0; m_err = 0;
    endtask

    task automatic model_dispatch();
        m_index = 9'h12A; m_step = 0; m_ack = 1; m_in_irq = 1; m_executing = 1;
    endtask

    task automatic model_step();
        m_ack = 0;
        if (m_idle) begin
            m_idle = 0;
            m_fetching = 1;
        end else if (m_fetching) begin
            if (bus.mem_ready) begin
                if (!m_prefixed && bus.mem_data == 8'hCB) begin
                    m_prefixed = 1;
                end else begin
                    m_index = {m_prefixed, bus.mem_data};
                    m_step = 0; m_prefixed = 0; m_fetching = 0; m_executing = 1; m_in_irq = 0;
                    $display("instr index=%h", m_index);
                end
            end
        end else if (m_sleeping) begin
            if (bus.irq_pending) begin
                m_sleeping = 0;
                if (bus.ime) model_dispatch();
                else m_fetching = 1;
            end
        end else if (m_executing && !(bus.ctrl_mem && !bus.mem_ready)) begin
            if (bus.ctrl_done || m_step == 7) begin
                if (!bus.ctrl_done) m_err = 1;
                if (bus.irq_pending && bus.ime && !m_in_irq) begin
                    model_dispatch();
                end else if (HALT_EN && m_index == 9'h076) begin
                    m_executing = 0; m_sleeping = 1;
                end else begin
                    m_executing = 0; m_fetching = 1;
                end
            end else begin
                m_step = m_step + 1;
            end
        end
    endtask

    function automatic logic [16:0] model_out();
        logic [2:0] s;
        s = m_step[2:0];
        return {m_index, s, m_executing, m_fetching, m_ack, m_sleeping, m_err};
    endfunction

    initial begin
        // Directed table: inputs applied for one cycle, outputs expected after that edge.
        vecs[0]  = mk(8'h00, 1, 0, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(8'h00, 1, 0, 0, 0, 0, 9'h000, 0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(8'h00, 0, 1, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0, 0);
        vecs[3]  = mk(8'hCB, 1, 0, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0, 0);
        vecs[4]  = mk(8'h11, 1, 0, 0, 0, 0, 9'h111, 0, 1, 0, 0, 0, 0);
        vecs[5]  = mk(8'h00, 0, 0, 0, 0, 0, 9'h111, 1, 1, 0, 0, 0, 0);
        vecs[6]  = mk(8'h00, 0, 1, 0, 0, 0, 9'h111, 1, 0, 1, 0, 0, 0);
        vecs[7]  = mk(8'h05, 1, 0, 0, 0, 0, 9'h005, 0, 1, 0, 0, 0, 0);
        vecs[8]  = mk(8'h00, 0, 0, 0, 0, 0, 9'h005, 1, 1, 0, 0, 0, 0);
        vecs[9]  = mk(8'h00, 0, 0, 1, 0, 0, 9'h005, 1, 1, 0, 0, 0, 0);
        vecs[10] = mk(8'h00, 0, 0, 1, 0, 0, 9'h005, 1, 1, 0, 0, 0, 0);
        vecs[11] = mk(8'h00, 0, 0, 1, 0, 0, 9'h005, 1, 1, 0, 0, 0, 0);
        vecs[12] = mk(8'h00, 1, 0, 1, 0, 0, 9'h005, 2, 1, 0, 0, 0, 0);
        vecs[13] = mk(8'h00, 0, 1, 0, 1, 1, 9'h12A, 0, 1, 0, 1, 0, 0);
        vecs[14] = mk(8'h00, 0, 0, 0, 1, 1, 9'h12A, 1, 1, 0, 0, 0, 0);
        vecs[15] = mk(8'h00, 0, 1, 0, 1, 1, 9'h12A, 1, 0, 1, 0, 0, 0);
        vecs[16] = mk(8'h00, 0, 0, 0, 0, 0, 9'h12A, 1, 0, 1, 0, 0, 0);
        vecs[17] = mk(8'h76, 1, 0, 0, 0, 0, 9'h076, 0, 1, 0, 0, 0, 0);
        vecs[18] = mk(8'h00, 0, 1, 0, 0, 0, 9'h076, 0, 0, !HALT_EN, 0, HALT_EN, 0);
        vecs[19] = mk(8'h00, 0, 0, 0, 1, 0, 9'h076, 0, 0, 1, 0, 0, 0);
        vecs[20] = mk(8'h00, 1, 0, 0, 0, 0, 9'h000, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            vecs[21 + i] = mk(8'h00, 0, 0, 0, 0, 0, 9'h000, 3'(i + 1), 1, 0, 0, 0, 0);
        vecs[28] = mk(8'h00, 0, 0, 0, 0, 0, 9'h000, 7, 0, 1, 0, 0, 1);

        drive(8'h00, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #12;
        check("reset_state", dut_out(), 17'h0);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].data, vecs[i].rdy, vecs[i].done, vecs[i].mem, vecs[i].irq, vecs[i].ie);
            tick();
            $display("vec %0d addr=%h step=%0d ev=%b fr=%b ack=%b hlt=%b err=%b", i,
                     bus.ucode_addr, bus.step, bus.exec_valid, bus.fetch_req, bus.irq_ack, bus.halted, bus.seq_err);
            check($sformatf("vec%0d", i), dut_out(),
                  {vecs[i].addr, vecs[i].stp, vecs[i].ev, vecs[i].fr, vecs[i].ack, vecs[i].hlt, vecs[i].err});
        end

        // Asynchronous reset in the middle of an instruction, away from any clock edge.
        drive(8'h42, 1, 0, 0, 0, 0);
        tick();
        check("exec_before_rst", dut_out(), {9'h042, 3'd0, 5'b10001});
        drive(8'h00, 0, 0, 1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        $display("async rst addr=%h ev=%b err=%b", bus.ucode_addr, bus.exec_valid, bus.seq_err);
        check("async_rst", dut_out(), 17'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        check("fetch_after_rst", dut_out(), {9'h000, 3'd0, 5'b01000});

        // Randomized phase against the reference model, from a fresh reset.
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 3) == 0) ? 8'hCB : (($urandom_range(0, 3) == 0) ? 8'h76 : 8'($urandom)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check("rand_async_rst", dut_out(), 17'h0);
                rst = 1'b0;
            end
            model_step();
            tick();
            check($sformatf("rand%0d", c), dut_out(), model_out());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
